// File: rtl/alien_matrix_mover.sv
// alien_matrix_mover: owns the formation top-left corner, marches it
// sideways every N frames, steps down at the edges, speeds up as aliens die.
module alien_matrix_mover #(
  parameter int START_X      = 64,
  parameter int START_Y      = 32,
  parameter int CELL_BITS    = 5,
  parameter int COLS         = 8,
  parameter int ROWS         = 4,
  parameter int STEP_X       = 8,
  parameter int STEP_Y       = 16,
  parameter int LEFT_LIMIT   = 0,
  parameter int RIGHT_LIMIT  = 639,
  parameter int BOTTOM_LIMIT = 400,
  parameter int SPEED_SHIFT  = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             gameStart,
  input  logic             levelRestart,
  input  logic             freeze,
  input  logic [COLS-1:0]  aliveCols,
  input  logic [ROWS-1:0]  aliveRows,
  input  logic [5:0]       aliveCount,
  output logic [10:0]      alienMatrixTLX,
  output logic [10:0]      alienMatrixTLY,
  output logic             movingRight,
  output logic             stepPulse,
  output logic             landed,
  output logic             cleared
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LANDED,
    CLEARED
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [10:0] tlx_nx;
  logic [10:0] tly_nx;
  logic        mr_nx;
  logic        sp_nx;
  logic        landed_nx;
  logic        cleared_nx;
  logic [5:0]  cnt;
  logic [5:0]  cnt_nx;
  logic [5:0]  period;
  logic [10:0] col_lo;
  logic [10:0] col_hi;
  logic [10:0] row_bot;
  logic [10:0] left_edge;
  logic [10:0] right_ex;
  logic [10:0] tly_dn;
  logic [11:0] bottom_ex;
  logic        fits_right;
  logic        fits_left;
  logic        lands;
  logic        empty;
  logic        frame_due;
  logic        step_due;

  always_comb begin
    col_lo = '0;
    col_hi = '0;
    for (int c = COLS - 1; c >= 0; c--)
      if (aliveCols[c]) col_lo = 11'(c);
    for (int c = 0; c < COLS; c++)
      if (aliveCols[c]) col_hi = 11'(c);
  end

  // highest row index is the lowest row on screen
  always_comb begin
    row_bot = '0;
    for (int r = 0; r < ROWS; r++)
      if (aliveRows[r]) row_bot = 11'(r);
  end

  assign period = 6'd1 + (aliveCount >> SPEED_SHIFT);

  // edges wrap mod 2^11 so a top-left that went "negative" stays coherent
  assign left_edge = alienMatrixTLX + (col_lo << CELL_BITS);
  assign right_ex  = alienMatrixTLX
                   + ((col_hi + 11'd1) << CELL_BITS);
  assign tly_dn    = alienMatrixTLY + 11'(STEP_Y);
  assign bottom_ex = {1'b0, tly_dn}
                   + (({1'b0, row_bot} + 12'd1) << CELL_BITS);

  assign fits_right = ({1'b0, right_ex} + 12'(STEP_X))
                    <= 12'(RIGHT_LIMIT + 1);
  assign fits_left  = {1'b0, left_edge}
                    >= 12'(LEFT_LIMIT + STEP_X);
  assign lands      = (|aliveRows)
                    && (bottom_ex >= 12'(BOTTOM_LIMIT));

  assign empty     = (aliveCount == 6'd0) || (aliveCols == '0);
  assign frame_due = startOfFrame && !freeze;
  assign step_due  = ({1'b0, cnt} + 7'd1) >= {1'b0, period};

  always_comb begin
    state_nx   = state;
    tlx_nx     = alienMatrixTLX;
    tly_nx     = alienMatrixTLY;
    mr_nx      = movingRight;
    cnt_nx     = cnt;
    sp_nx      = 1'b0;
    landed_nx  = landed;
    cleared_nx = cleared;
    if (levelRestart) begin
      state_nx   = RUN;
      tlx_nx     = 11'(START_X);
      tly_nx     = 11'(START_Y);
      mr_nx      = 1'b1;
      cnt_nx     = '0;
      landed_nx  = 1'b0;
      cleared_nx = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gameStart) state_nx = RUN;
        end
        RUN: begin
          if (empty) begin
            state_nx   = CLEARED;
            cleared_nx = 1'b1;
          end else if (frame_due && step_due) begin
            cnt_nx = '0;
            sp_nx  = 1'b1;
            unique case (1'b1)
              movingRight && fits_right:
                tlx_nx = alienMatrixTLX + 11'(STEP_X);
              !movingRight && fits_left:
                tlx_nx = alienMatrixTLX - 11'(STEP_X);
              default: begin
                tly_nx = tly_dn;
                mr_nx  = !movingRight;
                if (lands) begin
                  state_nx  = LANDED;
                  landed_nx = 1'b1;
                end
              end
            endcase
          end else if (frame_due) begin
            cnt_nx = cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state          <= IDLE;
      alienMatrixTLX <= 11'(START_X);
      alienMatrixTLY <= 11'(START_Y);
      movingRight    <= 1'b1;
      stepPulse      <= 1'b0;
      landed         <= 1'b0;
      cleared        <= 1'b0;
      cnt            <= '0;
    end else begin
      state          <= state_nx;
      alienMatrixTLX <= tlx_nx;
      alienMatrixTLY <= tly_nx;
      movingRight    <= mr_nx;
      stepPulse      <= sp_nx;
      landed         <= landed_nx;
      cleared        <= cleared_nx;
      cnt            <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_alien_matrix_mover.sv
// Bench for alien_matrix_mover: vector table, corner-case sequences
// and a randomized run against an integer-arithmetic model.
module tb_alien_matrix_mover;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sof;
  logic        gs;
  logic        lr;
  logic        frz;
  logic [7:0]  cols;
  logic [3:0]  rows;
  logic [5:0]  cnt;
  logic [10:0] tlx;
  logic [10:0] tly;
  logic        mr;
  logic        sp;
  logic        ld;
  logic        cl;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alien_matrix_mover #(
    .RIGHT_LIMIT (335),
    .BOTTOM_LIMIT(80)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (sof),
    .gameStart     (gs),
    .levelRestart  (lr),
    .freeze        (frz),
    .aliveCols     (cols),
    .aliveRows     (rows),
    .aliveCount    (cnt),
    .alienMatrixTLX(tlx),
    .alienMatrixTLY(tly),
    .movingRight   (mr),
    .stepPulse     (sp),
    .landed        (ld),
    .cleared       (cl)
  );

  typedef struct {
    logic        s, g, l, f;
    logic [7:0]  c;
    logic [3:0]  r;
    logic [5:0]  n;
    logic [10:0] x, y;
    logic        em, ep, el, ec;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t v(logic s, g, l, f,
                             logic [7:0] c, logic [3:0] r,
                             logic [5:0] n, logic [10:0] x, y,
                             logic em, ep, el, ec);
    vec_t t;
    t.s = s; t.g = g; t.l = l; t.f = f;
    t.c = c; t.r = r; t.n = n;
    t.x = x; t.y = y;
    t.em = em; t.ep = ep; t.el = el; t.ec = ec;
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic s, g, l, f, logic [7:0] c,
                       logic [3:0] r, logic [5:0] n);
    sof = s; gs = g; lr = l; frz = f;
    cols = c; rows = r; cnt = n;
  endtask

  task automatic chk(string nm, logic [10:0] x, y,
                     logic em, ep, el, ec);
    total++;
    if ({tlx, tly, mr, sp, ld, cl} !== {x, y, em, ep, el, ec}) begin
      bad++;
      $display("FAIL %s: got x=%0d y=%0d r=%0b p=%0b l=%0b c=%0b want x=%0d y=%0d r=%0b p=%0b l=%0b c=%0b",
               nm, tlx, tly, mr, sp, ld, cl, x, y, em, ep, el, ec);
    end
  endtask

  // reference model: true integer position, states 0 idle 1 run 2 landed 3 cleared
  int m_st, m_x, m_y, m_r, m_p, m_cnt;

  task automatic model_reset;
    m_st = 0; m_x = 64; m_y = 32; m_r = 1; m_p = 0; m_cnt = 0;
  endtask

  task automatic model_cycle;
    int lo, hi, rb, per;
    bit dn;
    m_p = 0;
    if (lr) begin
      m_x = 64; m_y = 32; m_r = 1; m_cnt = 0; m_st = 1;
      return;
    end
    if (m_st == 0) begin
      if (gs) m_st = 1;
    end else if (m_st == 1) begin
      if (cnt == 0 || cols == 0) begin
        m_st = 3;
      end else if (sof && !frz) begin
        per = 1 + int'(cnt) / 4;
        if (m_cnt + 1 >= per) begin
          m_cnt = 0;
          m_p = 1;
          lo = -1; hi = 0; rb = 0; dn = 0;
          for (int c = 0; c < 8; c++) begin
            if (cols[c] && lo < 0) lo = c;
            if (cols[c]) hi = c;
          end
          for (int r = 0; r < 4; r++)
            if (rows[r]) rb = r;
          if (m_r != 0) begin
            if (m_x + (hi + 1) * 32 + 8 <= 336) m_x += 8;
            else begin dn = 1; m_r = 0; end
          end else begin
            if (m_x + lo * 32 >= 8) m_x -= 8;
            else begin dn = 1; m_r = 1; end
          end
          if (dn) begin
            m_y += 16;
            if (rows != 0 && m_y + (rb + 1) * 32 >= 80) m_st = 2;
          end
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 8'hFF, 4'h0, 6'd32);
    resetN = 1'b1;
    repeat (5) tick();
    chk("reset", 64, 32, 1, 0, 0, 0);
    resetN = 1'b0;

    tbl[0]  = v(0,0,0,0, 8'hFF, 4'h0, 32,  64, 32, 1,0,0,0);
    tbl[1]  = v(1,0,0,0, 8'hFF, 4'h0, 32,  64, 32, 1,0,0,0);
    tbl[2]  = v(1,0,0,0, 8'hFF, 4'h0, 32,  64, 32, 1,0,0,0);
    tbl[3]  = v(1,0,0,0, 8'hFF, 4'h0, 32,  64, 32, 1,0,0,0);
    tbl[4]  = v(0,1,0,0, 8'hFF, 4'h0, 32,  64, 32, 1,0,0,0);
    for (int i = 5; i <= 12; i++)
      tbl[i] = v(1,0,0,0, 8'hFF, 4'h0, 32, 64, 32, 1,0,0,0);
    tbl[13] = v(1,0,0,0, 8'hFF, 4'h0, 32,  72, 32, 1,1,0,0);
    tbl[14] = v(0,0,0,0, 8'hFF, 4'h0, 3,   72, 32, 1,0,0,0);
    tbl[15] = v(1,0,0,0, 8'hFF, 4'h0, 3,   80, 32, 1,1,0,0);
    tbl[16] = v(1,0,0,0, 8'hFF, 4'h0, 3,   80, 48, 0,1,0,0);
    tbl[17] = v(1,0,0,0, 8'hFF, 4'h0, 3,   72, 48, 0,1,0,0);
    tbl[18] = v(0,0,1,0, 8'hFF, 4'h0, 3,   64, 32, 1,0,0,0);
    tbl[19] = v(1,0,0,0, 8'hFF, 4'h1, 3,   72, 32, 1,1,0,0);
    tbl[20] = v(1,0,0,0, 8'hFF, 4'h1, 3,   80, 32, 1,1,0,0);
    tbl[21] = v(1,0,0,0, 8'hFF, 4'h1, 3,   80, 48, 0,1,1,0);
    tbl[22] = v(1,0,0,0, 8'hFF, 4'h1, 3,   80, 48, 0,0,1,0);
    tbl[23] = v(1,1,0,0, 8'hFF, 4'h1, 3,   80, 48, 0,0,1,0);
    tbl[24] = v(0,0,1,0, 8'hFF, 4'h1, 3,   64, 32, 1,0,0,0);
    tbl[25] = v(1,1,0,0, 8'hFF, 4'h1, 3,   72, 32, 1,1,0,0);
    tbl[26] = v(0,0,0,0, 8'hFF, 4'h1, 3,   72, 32, 1,0,0,0);

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].s, tbl[i].g, tbl[i].l, tbl[i].f,
            tbl[i].c, tbl[i].r, tbl[i].n);
      tick();
      chk($sformatf("vec%0d", i), tbl[i].x, tbl[i].y,
          tbl[i].em, tbl[i].ep, tbl[i].el, tbl[i].ec);
    end

    // kill mid-count shortens the period at once
    drive(0, 0, 1, 0, 8'hFF, 4'h0, 32); tick();
    repeat (3) begin drive(1, 0, 0, 0, 8'hFF, 4'h0, 32); tick(); end
    chk("midcount_hold", 64, 32, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 8'hFF, 4'h0, 15); tick();
    chk("midcount_step", 72, 32, 1, 1, 0, 0);

    // freeze holds the frame counter
    drive(0, 0, 1, 0, 8'hFF, 4'h0, 32); tick();
    repeat (4) begin drive(1, 0, 0, 0, 8'hFF, 4'h0, 32); tick(); end
    repeat (20) begin drive(1, 0, 0, 1, 8'hFF, 4'h0, 32); tick(); end
    chk("freeze_hold", 64, 32, 1, 0, 0, 0);
    repeat (4) begin drive(1, 0, 0, 0, 8'hFF, 4'h0, 32); tick(); end
    chk("unfreeze_count", 64, 32, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 8'hFF, 4'h0, 32); tick();
    chk("unfreeze_step", 72, 32, 1, 1, 0, 0);

    // columns 5..7 only: march past x=0 using wrapped top-left
    drive(0, 0, 1, 0, 8'hE0, 4'h0, 3); tick();
    repeat (2) begin drive(1, 0, 0, 0, 8'hE0, 4'h0, 3); tick(); end
    chk("narrow_right", 80, 32, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 8'hE0, 4'h0, 3); tick();
    chk("narrow_down1", 80, 48, 0, 1, 0, 0);
    repeat (30) begin drive(1, 0, 0, 0, 8'hE0, 4'h0, 3); tick(); end
    chk("narrow_left", 11'd1888, 48, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 8'hE0, 4'h0, 3); tick();
    chk("narrow_down2", 11'd1888, 64, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 8'hE0, 4'h0, 3); tick();
    chk("narrow_back", 11'd1896, 64, 1, 1, 0, 0);

    // cleared on empty formation
    drive(0, 0, 1, 0, 8'hFF, 4'h0, 32); tick();
    drive(1, 0, 0, 0, 8'hFF, 4'h0, 0); tick();
    chk("cleared", 64, 32, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 8'hFF, 4'h0, 3); tick();
    chk("cleared_hold", 64, 32, 1, 0, 0, 1);
    drive(0, 0, 1, 0, 8'hFF, 4'h0, 32); tick();
    chk("cleared_exit", 64, 32, 1, 0, 0, 0);

    // async reset while stepPulse is high
    drive(1, 0, 0, 0, 8'hFF, 4'h0, 3); tick();
    chk("pre_reset_step", 72, 32, 1, 1, 0, 0);
    #2 resetN = 1'b1;
    #1 chk("async_reset", 64, 32, 1, 0, 0, 0);
    tick();
    resetN = 1'b0;
    drive(1, 0, 0, 0, 8'hFF, 4'h0, 3); tick();
    chk("reset_idle", 64, 32, 1, 0, 0, 0);

    // randomized run against the model
    resetN = 1'b1;
    model_reset();
    tick();
    resetN = 1'b0;
    for (int i = 0; i < 600; i++) begin
      sof  = ($urandom % 2) == 0;
      gs   = ($urandom % 8) == 0;
      lr   = ($urandom % 40) == 0;
      frz  = ($urandom % 6) == 0;
      cols = (($urandom % 16) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rows = 4'($urandom % 16);
      cnt  = (($urandom % 20) == 0) ? 6'd0 : 6'($urandom_range(1, 32));
      model_cycle();
      tick();
      chk($sformatf("rand%0d", i), 11'(m_x), 11'(m_y), m_r[0],
          m_p[0], m_st == 2, m_st == 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
